// File: rtl/winograd_tile_fetcher.sv
// winograd_tile_fetcher
// Walks a row-major image in on-chip memory and cuts it into overlapping
// 6x6 input tiles (stride 4) for a Winograd F(4x4,3x3) tile controller.
// Elements outside the image are zero-padded. Each finished tile is offered
// on a valid/ready handshake.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start                one-cycle frame start pulse (sampled in IDLE only)
//   img_rows, img_cols   image height H and width W
//   base_addr            address of image element (0,0)
//   mem_rd_en/addr/data  memory read port, data returns one cycle after en
//   tile_out             current 6x6 tile, row-major
//   tile_valid/ready     tile handshake
//   tile_row_idx/col_idx tile grid position (tr, tc)
//   busy, done, err      frame in progress, end-of-frame pulse, bad dimensions
module winograd_tile_fetcher #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_DIM    = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [7:0]                           img_rows,
  input  logic [7:0]                           img_cols,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  output logic                                 mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]                mem_rd_data,
  output logic [0:5][0:5][DATA_WIDTH-1:0]      tile_out,
  output logic                                 tile_valid,
  input  logic                                 tile_ready,
  output logic [7:0]                           tile_row_idx,
  output logic [7:0]                           tile_col_idx,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [2:0]            slot_i;
  logic [2:0]            slot_j;
  logic [ADDR_WIDTH-1:0] tile_row_start;
  logic [ADDR_WIDTH-1:0] tile_base;
  logic [ADDR_WIDTH-1:0] row_ptr;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  pend_valid;
  logic                  pend_in;
  logic [2:0]            pend_i;
  logic [2:0]            pend_j;

  logic                  dims_bad;
  logic [8:0]            tiles_r;
  logic [8:0]            tiles_c;
  logic                  last_row;
  logic                  last_col;
  logic                  last_slot;
  logic [9:0]            img_r;
  logic [9:0]            img_c;
  logic                  in_image;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] cols_ext;
  logic [ADDR_WIDTH-1:0] cols_x4;

  assign dims_bad = (rows_q < 8'd3) || (cols_q < 8'd3) ||
                    (int'(rows_q) > MAX_DIM) || (int'(cols_q) > MAX_DIM);

  // ceil((D-2)/4) == (D+1)>>2 for D >= 2
  assign tiles_r  = ({1'b0, rows_q} + 9'd1) >> 2;
  assign tiles_c  = ({1'b0, cols_q} + 9'd1) >> 2;
  assign last_row = (({1'b0, tile_row_idx} + 9'd1) == tiles_r);
  assign last_col = (({1'b0, tile_col_idx} + 9'd1) == tiles_c);
  assign last_slot = (slot_i == 3'd5) && (slot_j == 3'd5);

  assign img_r    = {tile_row_idx, 2'b00} + {7'd0, slot_i};
  assign img_c    = {tile_col_idx, 2'b00} + {7'd0, slot_j};
  assign in_image = (img_r < {2'b00, rows_q}) && (img_c < {2'b00, cols_q});

  // row_ptr tracks base + r*W + 4tc for the current tile row, so the
  // element address is only an add of the column offset.
  assign cols_ext = ADDR_WIDTH'(cols_q);
  assign cols_x4  = cols_ext << 2;
  assign cur_addr = row_ptr + ADDR_WIDTH'(slot_j);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    done        = 1'b0;
    tile_valid  = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = addr_hold;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_SETUP;
      end
      S_SETUP: begin
        busy       = 1'b1;
        state_next = dims_bad ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        if (in_image) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = cur_addr;
        end
        if (last_slot) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy       = 1'b1;
        state_next = S_PRESENT;
      end
      S_PRESENT: begin
        busy       = 1'b1;
        tile_valid = 1'b1;
        if (tile_ready) state_next = (last_row && last_col) ? S_DONE : S_SETUP;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q         <= '0;
      cols_q         <= '0;
      err            <= 1'b0;
      tile_row_idx   <= '0;
      tile_col_idx   <= '0;
      slot_i         <= '0;
      slot_j         <= '0;
      tile_row_start <= '0;
      tile_base      <= '0;
      row_ptr        <= '0;
      addr_hold      <= '0;
      pend_valid     <= 1'b0;
      pend_in        <= 1'b0;
      pend_i         <= '0;
      pend_j         <= '0;
      tile_out       <= '0;
    end else begin
      addr_hold  <= mem_rd_addr;
      pend_valid <= (state == S_FETCH);
      pend_in    <= in_image;
      pend_i     <= slot_i;
      pend_j     <= slot_j;

      // Read data of the previous slot lands one cycle after issue.
      if (pend_valid) begin
        tile_out[pend_i][pend_j] <= pend_in ? mem_rd_data : '0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            rows_q         <= img_rows;
            cols_q         <= img_cols;
            err            <= 1'b0;
            tile_row_idx   <= '0;
            tile_col_idx   <= '0;
            tile_row_start <= base_addr;
            tile_base      <= base_addr;
          end
        end
        S_SETUP: begin
          row_ptr <= tile_base;
          slot_i  <= '0;
          slot_j  <= '0;
          if (dims_bad) err <= 1'b1;
        end
        S_FETCH: begin
          if (slot_j == 3'd5) begin
            slot_j  <= '0;
            slot_i  <= slot_i + 3'd1;
            row_ptr <= row_ptr + cols_ext;
          end else begin
            slot_j <= slot_j + 3'd1;
          end
        end
        S_PRESENT: begin
          if (tile_ready && !(last_row && last_col)) begin
            if (last_col) begin
              tile_col_idx   <= '0;
              tile_row_idx   <= tile_row_idx + 8'd1;
              tile_row_start <= tile_row_start + cols_x4;
              tile_base      <= tile_row_start + cols_x4;
            end else begin
              tile_col_idx <= tile_col_idx + 8'd1;
              tile_base    <= tile_base + ADDR_WIDTH'(4);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_tile_fetcher.sv
// tb_winograd_tile_fetcher
// Directed self-checking bench for winograd_tile_fetcher. Memory holds
// mem[a] = a, so every expected tile element is the element's own address
// (or 0 when padded), computed here with a plain multiply.
module tb_winograd_tile_fetcher;

  localparam int DW = 16;
  localparam int AW = 12;

  logic                          clk;
  logic                          rst;
  logic                          start;
  logic [7:0]                    img_rows;
  logic [7:0]                    img_cols;
  logic [AW-1:0]                 base_addr;
  logic                          mem_rd_en;
  logic [AW-1:0]                 mem_rd_addr;
  logic [DW-1:0]                 mem_rd_data;
  logic [0:5][0:5][DW-1:0]       tile_out;
  logic                          tile_valid;
  logic                          tile_ready;
  logic [7:0]                    tile_row_idx;
  logic [7:0]                    tile_col_idx;
  logic                          busy;
  logic                          done;
  logic                          err;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int cyc;
  int reads;
  int done_count;
  int total;
  int bad;

  winograd_tile_fetcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DIM(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .img_rows     (img_rows),
    .img_cols     (img_cols),
    .base_addr    (base_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .tile_out     (tile_out),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .tile_row_idx (tile_row_idx),
    .tile_col_idx (tile_col_idx),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_addr];
      reads       <= reads + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int expElem(int h, int w, int base, int tr, int tc, int i, int j);
    int r = 4 * tr + i;
    int c = 4 * tc + j;
    if (r < h && c < w) return (base + r * w + c) % (1 << AW);
    return 0;
  endfunction

  function automatic int expReads(int h, int w, int tr, int tc);
    int nr = h - 4 * tr;
    int nc = w - 4 * tc;
    if (nr > 6) nr = 6;
    if (nc > 6) nc = 6;
    return nr * nc;
  endfunction

  // Pulses start so that it is sampled on the returned edge number.
  task automatic applyStimulus(input int h, input int w, input int base, output int t0);
    @(negedge clk);
    img_rows  = 8'(h);
    img_cols  = 8'(w);
    base_addr = AW'(base);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic waitValid();
    int n = 0;
    while (!tile_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tile_valid) checkOutput("valid_timeout", 0, 1);
  endtask

  // hold == 0: tile_ready tied high. hold > 0: ready held low that many
  // cycles in PRESENT (with a stray start pulse), then raised for one edge.
  task automatic runFrame(input int h, input int w, input int base, input int hold);
    int ntr = (h + 1) / 4;
    int ntc = (w + 1) / 4;
    int t_ref, rd_snap, done_snap;
    tile_ready = (hold == 0);
    applyStimulus(h, w, base, t_ref);
    checkOutput("busy_rise", busy, 1);
    checkOutput("err_clear", err, 0);
    rd_snap   = reads;
    done_snap = done_count;
    for (int tr = 0; tr < ntr; tr++) begin
      for (int tc = 0; tc < ntc; tc++) begin
        waitValid();
        checkOutput("valid_time", cyc - t_ref, 38);
        checkOutput("idx_row", tile_row_idx, tr);
        checkOutput("idx_col", tile_col_idx, tc);
        for (int i = 0; i < 6; i++)
          for (int j = 0; j < 6; j++)
            checkOutput($sformatf("elem_%0d_%0d_%0d_%0d", tr, tc, i, j),
                        tile_out[i][j], expElem(h, w, base, tr, tc, i, j));
        checkOutput("tile_reads", reads - rd_snap, expReads(h, w, tr, tc));
        if (hold > 0) begin
          for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (k == 5) begin
              start    = 1'b1;
              img_rows = 8'd2;
            end
            if (k == 6) start = 1'b0;
            checkOutput("hold_valid", tile_valid, 1);
            checkOutput("hold_idx", {tile_row_idx, tile_col_idx}, {8'(tr), 8'(tc)});
            checkOutput("hold_elem", tile_out[5][5], expElem(h, w, base, tr, tc, 5, 5));
            checkOutput("hold_reads", reads - rd_snap, expReads(h, w, tr, tc));
          end
          tile_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        t_ref = cyc;
        if (hold > 0) tile_ready = 1'b0;
        rd_snap = reads;
        checkOutput("valid_drop", tile_valid, 0);
      end
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 0);
    @(posedge clk);
    #1;
    checkOutput("done_low", done, 0);
    checkOutput("done_count", done_count - done_snap, 1);
    checkOutput("frame_err", err, 0);
    tile_ready = 1'b0;
  endtask

  initial begin
    int t0, rd_snap, done_snap, n;
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);
    cyc = 0; reads = 0; done_count = 0; total = 0; bad = 0;
    mem_rd_data = '0;
    rst = 1'b1; start = 1'b0; tile_ready = 1'b0;
    img_rows = '0; img_cols = '0; base_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", tile_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rd_en", mem_rd_en, 0);
    checkOutput("rst_tile", tile_out != '0, 0);
    checkOutput("rst_idx", {tile_row_idx, tile_col_idx}, 0);
    rst = 1'b0;

    $display("[TB] single 6x6 tile, ready tied high");
    runFrame(6, 6, 0, 0);

    $display("[TB] 10x10 image at base 100");
    runFrame(10, 10, 100, 0);

    $display("[TB] 7x7 image with padding");
    runFrame(7, 7, 0, 0);

    $display("[TB] backpressure and ignored start");
    runFrame(6, 6, 50, 20);

    $display("[TB] bad dimensions");
    rd_snap   = reads;
    done_snap = done_count;
    applyStimulus(2, 8, 0, t0);
    checkOutput("bad_done0", done, 0);
    @(posedge clk);
    #1;
    checkOutput("bad_done1", done, 1);
    checkOutput("bad_err", err, 1);
    @(posedge clk);
    #1;
    checkOutput("bad_done2", done, 0);
    checkOutput("bad_err_sticky", err, 1);
    checkOutput("bad_busy", busy, 0);
    checkOutput("bad_reads", reads - rd_snap, 0);
    checkOutput("bad_done_count", done_count - done_snap, 1);

    $display("[TB] good frame after error clears err");
    runFrame(7, 7, 0, 0);

    $display("[TB] reset during fetch of tile 2");
    tile_ready = 1'b1;
    applyStimulus(10, 10, 100, t0);
    n = 0;
    while (tile_row_idx != 8'd1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_tile2", tile_row_idx, 1);
    repeat (10) @(negedge clk);
    checkOutput("mid_fetch_busy", busy, 1);
    done_snap = done_count;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", tile_valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_rd_en", mem_rd_en, 0);
    checkOutput("arst_rd_addr", mem_rd_addr, 0);
    checkOutput("arst_idx", {tile_row_idx, tile_col_idx}, 0);
    checkOutput("arst_tile", tile_out != '0, 0);
    tile_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("arst_no_done", done_count - done_snap, 0);
    checkOutput("arst_idle", busy, 0);
    runFrame(7, 7, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
